// File: rtl/dm_store_rmw.sv
// Store-side byte-lane unit: SW writes straight through, SB/SH do a
// read-modify-write on word-wide memory that has no byte enables.
// Misaligned or unsupported stores finish with err and never touch memory.
module dm_store_rmw #(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    input  logic [5:0]        OP,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    // Store opcodes (instr[31:26]) as encoded by the CPU decoder.
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        accept;
    logic        is_sb;
    logic        is_sh_ok;
    logic        is_sw_ok;
    logic        bad_req;

    logic        sb_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] merged;

    // Upper address bits lie outside the data memory and are deliberately ignored.
    logic        unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[31:MEM_AW+2]};

    assign accept   = (state == IDLE) && req;
    assign is_sb    = (OP == OP_SB);
    assign is_sh_ok = (OP == OP_SH) && !addr[0];
    assign is_sw_ok = (OP == OP_SW) && (addr[1:0] == 2'b00);
    assign bad_req  = !(is_sb || is_sh_ok || is_sw_ok);

    // State register; an asynchronous reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-decoded, glitch-free strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        mem_rd_en  = 1'b0;
        mem_we     = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    if (bad_req)       state_next = RESP;
                    else if (is_sw_ok) state_next = WRITE;
                    else               state_next = READ;
                end
            end
            READ: begin
                mem_rd_en  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                state_next = WRITE;
            end
            WRITE: begin
                mem_we     = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                done       = 1'b1;
                err        = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Merge the store data into the word read back from memory.
    always_comb begin
        merged = mem_rdata;
        if (sb_q) begin
            merged[8*lane_q +: 8] = wdata_q[7:0];
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // Operand latches and memory-side address/data registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb_q      <= 1'b0;
            lane_q    <= 2'b00;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            sb_q      <= is_sb;
            lane_q    <= addr[1:0];
            wdata_q   <= wdata;
            err_q     <= bad_req;
            mem_addr  <= addr[MEM_AW+1:2];
            mem_wdata <= wdata;
        end else if (state == WAIT) begin
            mem_wdata <= merged;
        end
    end

endmodule

// File: tb/tb_dm_store_rmw.sv
// Self-checking bench for dm_store_rmw: table of store vectors against a
// behavioural word memory, a write scoreboard, plus busy/back-to-back/reset sequences.
module tb_dm_store_rmw;

    localparam int MEM_AW = 10;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_LW = 6'b100011;

    logic              clk;
    logic              rstn;
    logic              req;
    logic [5:0]        op;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic              err;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;

    logic [31:0] mem [0:(1<<MEM_AW)-1];

    typedef struct {
        logic [MEM_AW-1:0] wa;
        logic [31:0]       wd;
    } wr_t;
    wr_t sb_q[$];

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] init;
        logic [31:0] exp_word;
        logic        exp_err;
        int          exp_lat;
    } vec_t;
    vec_t vecs[13];

    int vec_count = 0;
    int miscompares = 0;

    dm_store_rmw #(.MEM_AW(MEM_AW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .OP        (op),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: write on clk, read data one cycle after mem_rd_en.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every mem_we must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we || mem_rd_en) check("rd_we_exclusive", {31'd0, mem_we && mem_rd_en}, 32'd0);
        if (mem_we) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t w;
                w = sb_q.pop_front();
                check("wr_addr", {22'd0, mem_addr}, {22'd0, w.wa});
                check("wr_data", mem_wdata, w.wd);
            end
        end
    end

    // Issue one store and check timing, err, memory traffic and final memory word.
    // Called at a negedge; returns one cycle after done has been seen.
    task automatic run_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_word, input logic exp_err, input int exp_lat,
                          input bit busy_poke);
        int w = 0;
        int k = 0;
        int rd_cnt = 0;
        int we_cnt = 0;
        int rd_first = 0;
        int we_first = 0;
        logic ready_k1 = 1'b1;
        logic err_seen = 1'b0;
        bit seen_done = 0;
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ready) check("ready_timeout", 32'd0, 32'd1);
        req = 1'b1; op = o; addr = a; wdata = d;
        if (!exp_err) sb_q.push_back('{wa: a[MEM_AW+1:2], wd: exp_word});
        while (!seen_done && k < 12) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                ready_k1 = ready;
                if (busy_poke) begin
                    req = 1'b1; op = OP_SW; addr = 32'h20; wdata = 32'hDEADBEEF;
                end else begin
                    req = 1'b0; op = OP_SW; addr = $urandom; wdata = $urandom;
                end
            end
            if (k == 3) begin
                req = 1'b0; addr = $urandom; wdata = $urandom;
            end
            if (mem_rd_en) begin
                rd_cnt++;
                if (rd_first == 0) rd_first = k;
            end
            if (mem_we) begin
                we_cnt++;
                if (we_first == 0) we_first = k;
            end
            if (done) begin
                seen_done = 1;
                err_seen = err;
            end
        end
        req = 1'b0;
        if (!seen_done) check("done_timeout", 32'd0, 32'd1);
        check("ready_drop", {31'd0, ready_k1}, 32'd0);
        check("done_lat", k, exp_lat);
        check("err", {31'd0, err_seen}, {31'd0, exp_err});
        check("rd_cnt", rd_cnt, (exp_lat == 4) ? 1 : 0);
        if (exp_lat == 4) check("rd_first", rd_first, 1);
        check("we_cnt", we_cnt, (exp_lat > 1) ? 1 : 0);
        if (exp_lat > 1) check("we_first", we_first, exp_lat - 1);
        check("mem_word", mem[a[MEM_AW+1:2]], exp_word);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0]  = '{OP_SW, 32'h10,   32'hCAFEF00D, 32'h11223344, 32'hCAFEF00D, 1'b0, 2};
        vecs[1]  = '{OP_SB, 32'h12,   32'hAABBCCDD, 32'h11223344, 32'h11DD3344, 1'b0, 4};
        vecs[2]  = '{OP_SB, 32'h10,   32'hAABBCCDD, 32'h11223344, 32'h112233DD, 1'b0, 4};
        vecs[3]  = '{OP_SB, 32'h11,   32'hAABBCCDD, 32'h11223344, 32'h1122DD44, 1'b0, 4};
        vecs[4]  = '{OP_SB, 32'h13,   32'hAABBCCDD, 32'h11223344, 32'hDD223344, 1'b0, 4};
        vecs[5]  = '{OP_SH, 32'h12,   32'h0000BEEF, 32'h11223344, 32'hBEEF3344, 1'b0, 4};
        vecs[6]  = '{OP_SH, 32'h10,   32'h0000BEEF, 32'h11223344, 32'h1122BEEF, 1'b0, 4};
        vecs[7]  = '{OP_SH, 32'h13,   32'h0000BEEF, 32'h11223344, 32'h11223344, 1'b1, 1};
        vecs[8]  = '{OP_SW, 32'h12,   32'hCAFEF00D, 32'h11223344, 32'h11223344, 1'b1, 1};
        vecs[9]  = '{OP_LW, 32'h10,   32'hCAFEF00D, 32'h11223344, 32'h11223344, 1'b1, 1};
        vecs[10] = '{OP_SB, 32'h7FF,  32'h0000005A, 32'h00000000, 32'h5A000000, 1'b0, 4};
        vecs[11] = '{OP_SW, 32'h100C, 32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5, 1'b0, 2};
        vecs[12] = '{OP_SH, 32'h2,    32'h12345678, 32'hFFFFFFFF, 32'h5678FFFF, 1'b0, 4};

        for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 32'h0;
        rstn = 1'b0; req = 1'b0; op = 6'd0; addr = 32'd0; wdata = 32'd0;
        mem_rdata = 32'd0;

        // Reset state.
        #12;
        check("rst_ready",     {31'd0, ready},     32'd1);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_err",       {31'd0, err},       32'd0);
        check("rst_rd_en",     {31'd0, mem_rd_en}, 32'd0);
        check("rst_we",        {31'd0, mem_we},    32'd0);
        check("rst_mem_addr",  {22'd0, mem_addr},  32'd0);
        check("rst_mem_wdata", mem_wdata,          32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Table of single stores.
        for (int i = 0; i < 13; i++) begin
            mem[vecs[i].a[MEM_AW+1:2]] = vecs[i].init;
            run_op(vecs[i].op, vecs[i].a, vecs[i].d, vecs[i].exp_word,
                   vecs[i].exp_err, vecs[i].exp_lat, 1'b0);
        end

        // Busy: a second request held through READ/WAIT is ignored, then
        // an SB issued in the first IDLE cycle after done is accepted.
        mem[4] = 32'h11223344;
        mem[8] = 32'h00000000;
        run_op(OP_SB, 32'h11, 32'h00000077, 32'h11227744, 1'b0, 4, 1'b1);
        check("busy_ignored", mem[8], 32'h00000000);
        run_op(OP_SB, 32'h13, 32'h000000EE, 32'hEE227744, 1'b0, 4, 1'b0);

        // Reset during WAIT of an SB abandons the write.
        mem[4] = 32'h11223344;
        req = 1'b1; op = OP_SB; addr = 32'h12; wdata = 32'hAABBCCDD;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("pre_rst_wait", {31'd0, ready}, 32'd0);
        #2 rstn = 1'b0;
        #1;
        check("arst_ready",     {31'd0, ready},     32'd1);
        check("arst_we",        {31'd0, mem_we},    32'd0);
        check("arst_done",      {31'd0, done},      32'd0);
        check("arst_mem_addr",  {22'd0, mem_addr},  32'd0);
        check("arst_mem_wdata", mem_wdata,          32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_done_after_rst", {31'd0, done}, 32'd0);
        end
        check("rst_mem_kept", mem[4], 32'h11223344);
        run_op(OP_SW, 32'h10, 32'h12345678, 32'h12345678, 1'b0, 2, 1'b0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
